// File: rtl/alu_ctrl.sv
// ALU sequencer: 8x16 register file, flag register and a fixed
// IDLE/DECODE/EXEC/WB pipeline wrapped around an external ALU.
module alu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   input  logic        ld_en,
   input  logic [2:0]  ld_addr,
   input  logic [15:0] ld_data,
   input  logic [2:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [4:0]  alu_f,
   output logic        alu_cin,
   input  logic [15:0] alu_result,
   input  logic [5:0]  alu_status,
   output logic [5:0]  flags,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      EXEC,
      WB
   } state_t;

   state_t      state_q;
   logic [15:0] instr_q;
   logic [15:0] regs_q [8];
   logic [5:0]  flags_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [4:0]  f_q;
   logic        cin_q;
   logic [15:0] res_q;
   logic [5:0]  stat_q;
   logic        done_q;
   logic        err_q;

   logic [4:0]  op;
   logic [2:0]  rd;
   logic [2:0]  rs1;
   logic [2:0]  rs2;
   logic        use_c;
   logic        flag_we;
   logic        legal;

   assign op      = instr_q[15:11];
   assign rd      = instr_q[10:8];
   assign rs1     = instr_q[7:5];
   assign rs2     = instr_q[4:2];
   assign use_c   = instr_q[1];
   assign flag_we = instr_q[0];

   always_comb begin
      legal = 1'b0;
      casez (op)
         5'b00001,
         5'b00011,
         5'b001??,
         5'b010??,
         5'b10???: legal = 1'b1;
         default:  legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         instr_q <= '0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
         flags_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         cin_q   <= 1'b0;
         res_q   <= '0;
         stat_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // load lands at the accept edge, so DECODE sees it
               if (ld_en) regs_q[ld_addr] <= ld_data;
               if (instr_valid) begin
                  instr_q <= instr;
                  state_q <= DECODE;
               end
            end
            DECODE: begin
               a_q     <= regs_q[rs1];
               b_q     <= regs_q[rs2];
               f_q     <= op;
               cin_q   <= use_c & flags_q[5];
               state_q <= EXEC;
            end
            EXEC: begin
               res_q   <= alu_result;
               stat_q  <= alu_status;
               done_q  <= 1'b1;
               err_q   <= ~legal;
               state_q <= WB;
            end
            WB: begin
               if (legal) begin
                  regs_q[rd] <= res_q;
                  if (flag_we) flags_q <= stat_q;
               end
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign rd_data     = regs_q[rd_addr];
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_f       = f_q;
   assign alu_cin     = cin_q;
   assign flags       = flags_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU stub, reference register/flag
// model, directed scenarios and randomized instruction traffic.
module tb_alu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        ld_en;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [4:0]  alu_f;
   logic        alu_cin;
   logic [15:0] alu_result;
   logic [5:0]  alu_status;
   logic [5:0]  flags;
   logic        busy;
   logic        done;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] mregs [8];
   logic [5:0]  mflags;

   alu_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr      (instr),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_f      (alu_f),
      .alu_cin    (alu_cin),
      .alu_result (alu_result),
      .alu_status (alu_status),
      .flags      (flags),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #10 clk = ~clk;

   function automatic logic is_legal(input logic [4:0] op);
      return (op == 5'd1) || (op == 5'd3) ||
             (op >= 5'd4 && op <= 5'd11) ||
             (op >= 5'd16 && op <= 5'd23);
   endfunction

   // status = {carry, zero, neg, ovf, even parity, low-nibble carry}
   function automatic logic [21:0] alu_fn(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [4:0]  f,
                                          input logic        ci);
      logic [16:0] r;
      logic [5:0]  s;
      case (f)
         5'd1:    r = {1'b0, a} + 17'd1;
         5'd3:    r = {1'b0, a} - 17'd1;
         5'd4:    r = {1'b0, a} + {1'b0, b};
         5'd5:    r = {1'b0, a} + {1'b0, b} + {16'd0, ci};
         5'd6:    r = {1'b0, a} - {1'b0, b};
         5'd7:    r = {1'b0, a} - {1'b0, b} - {16'd0, ci};
         5'd8:    r = {1'b0, a & b};
         5'd9:    r = {1'b0, a | b};
         5'd10:   r = {1'b0, a ^ b};
         5'd11:   r = {1'b0, ~a};
         default: r = {1'b0, (a << f[2:0]) ^ b};
      endcase
      s = {r[16], r[15:0] == 16'd0, r[15],
           (a[15] ^ r[15]) & (b[15] ^ r[15]), ~^r[15:0],
           ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15};
      if (!is_legal(f)) begin
         r = 17'h1DEAD;
         s = 6'h3F;
      end
      return {s, r[15:0]};
   endfunction

   always_comb {alu_status, alu_result} =
      alu_fn(alu_a, alu_b, alu_f, alu_cin);

   function automatic logic [15:0] mk(input logic [4:0] op,
                                      input logic [2:0] rd,
                                      input logic [2:0] rs1,
                                      input logic [2:0] rs2,
                                      input logic       uc,
                                      input logic       fw);
      return {op, rd, rs1, rs2, uc, fw};
   endfunction

   task automatic model_exec(input logic [15:0] ins);
      logic [21:0] o;
      if (is_legal(ins[15:11])) begin
         o = alu_fn(mregs[ins[7:5]], mregs[ins[4:2]], ins[15:11],
                    ins[1] & mflags[5]);
         mregs[ins[10:8]] = o[15:0];
         if (ins[0]) mflags = o[21:16];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
      mflags = 6'd0;
   endtask

   task automatic load(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      ld_en = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
      mregs[a] = d;
   endtask

   task automatic run_instr(input  logic [15:0] ins,
                            input  logic        ld,
                            input  logic [2:0]  la,
                            input  logic [15:0] ldd,
                            output int          done_at,
                            output int          done_cnt,
                            output int          err_cnt,
                            output logic        err_at_done,
                            output logic        cin_seen,
                            output logic        rdy4);
      @(negedge clk);
      instr = ins;
      instr_valid = 1'b1;
      ld_en = ld;
      ld_addr = la;
      ld_data = ldd;
      @(negedge clk);
      instr_valid = 1'b0;
      ld_en = 1'b0;
      done_at = -1;
      done_cnt = 0;
      err_cnt = 0;
      err_at_done = 1'b0;
      cin_seen = 1'b0;
      rdy4 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (done === 1'b1) begin
            if (done_at < 0) done_at = k;
            done_cnt++;
            err_at_done = err;
            cin_seen = alu_cin;
         end
         if (err === 1'b1) err_cnt++;
         if (k == 4) rdy4 = instr_ready;
         if (k < 6) @(negedge clk);
      end
      if (ld) mregs[la] = ldd;
      model_exec(ins);
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         rd_addr = i[2:0];
         #1;
         n_chk++;
         if (rd_data !== mregs[i]) begin
            n_fail++;
            $display("FAIL %s r%0d: got %h expected %h",
                     tag, i, rd_data, mregs[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ld_en = 1'b1;
      ld_addr = 3'd2;
      ld_data = 16'h1234;
      instr_valid = 1'b1;
      instr = mk(5'b00100, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      model_reset();
      n_chk++;
      if (instr_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset ready/busy: got %b/%b expected 1/0",
                  instr_ready, busy);
      end
      n_chk++;
      if ({done, err, alu_cin} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset done/err/cin: got %b expected 000",
                  {done, err, alu_cin});
      end
      n_chk++;
      if ({alu_a, alu_b, alu_f, flags} !== 43'd0) begin
         n_fail++;
         $display("FAIL reset operands/flags: got %h %h %h %h expected 0",
                  alu_a, alu_b, alu_f, flags);
      end
      check_all_regs("reset_regs");
      ld_en = 1'b0;
      instr_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      int da, dc, ec;
      logic ead, cs, r4;
      load(3'd1, 16'h0003);
      load(3'd2, 16'h0004);
      run_instr(mk(5'b00100, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1),
                1'b0, 3'd0, 16'd0, da, dc, ec, ead, cs, r4);
      n_chk++;
      if (da != 3 || dc != 1 || ec != 0) begin
         n_fail++;
         $display("FAIL add timing: got done_at=%0d cnt=%0d err=%0d expected 3/1/0",
                  da, dc, ec);
      end
      n_chk++;
      if (r4 !== 1'b1) begin
         n_fail++;
         $display("FAIL add ready_at_4: got %b expected 1", r4);
      end
      rd_addr = 3'd3;
      #1;
      n_chk++;
      if (rd_data !== 16'h0007) begin
         n_fail++;
         $display("FAIL add r3: got %h expected 0007", rd_data);
      end
      n_chk++;
      if (flags !== 6'h00) begin
         n_fail++;
         $display("FAIL add flags: got %h expected 00", flags);
      end
   endtask

   task automatic test_inc_carry();
      int da, dc, ec;
      logic ead, cs, r4;
      load(3'd1, 16'hFFFF);
      load(3'd0, 16'h0000);
      run_instr(mk(5'b00001, 3'd4, 3'd1, 3'd0, 1'b0, 1'b1),
                1'b0, 3'd0, 16'd0, da, dc, ec, ead, cs, r4);
      rd_addr = 3'd4;
      #1;
      n_chk++;
      if (rd_data !== 16'h0000 || flags !== 6'h32) begin
         n_fail++;
         $display("FAIL inc r4/flags: got %h/%h expected 0000/32",
                  rd_data, flags);
      end
      run_instr(mk(5'b00101, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0),
                1'b0, 3'd0, 16'd0, da, dc, ec, ead, cs, r4);
      n_chk++;
      if (cs !== 1'b1) begin
         n_fail++;
         $display("FAIL adc alu_cin: got %b expected 1", cs);
      end
      rd_addr = 3'd5;
      #1;
      n_chk++;
      if (rd_data !== 16'h0001 || flags !== 6'h32) begin
         n_fail++;
         $display("FAIL adc r5/flags: got %h/%h expected 0001/32",
                  rd_data, flags);
      end
   endtask

   task automatic test_illegal();
      int da, dc, ec;
      logic ead, cs, r4;
      load(3'd6, 16'hA5A5);
      run_instr(mk(5'b00010, 3'd6, 3'd1, 3'd2, 1'b0, 1'b1),
                1'b0, 3'd0, 16'd0, da, dc, ec, ead, cs, r4);
      n_chk++;
      if (da != 3 || dc != 1 || ec != 1 || ead !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal err/done: got at=%0d dc=%0d ec=%0d ed=%b expected 3/1/1/1",
                  da, dc, ec, ead);
      end
      rd_addr = 3'd6;
      #1;
      n_chk++;
      if (rd_data !== 16'hA5A5 || flags !== 6'h32) begin
         n_fail++;
         $display("FAIL illegal r6/flags: got %h/%h expected a5a5/32",
                  rd_data, flags);
      end
   endtask

   task automatic test_reset_mid();
      int dc;
      load(3'd1, 16'h1111);
      load(3'd2, 16'h2222);
      @(negedge clk);
      instr = mk(5'b00100, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset in_exec: got busy=%b done=%b expected 1/0",
                  busy, done);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      n_chk++;
      if (instr_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset state: got rdy=%b done=%b err=%b expected 1/0/0",
                  instr_ready, done, err);
      end
      n_chk++;
      if (flags !== 6'd0 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_reset flags/ops: got %h %h %h expected 0",
                  flags, alu_a, alu_b);
      end
      check_all_regs("mid_reset_regs");
      dc = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done !== 1'b0) dc++;
      end
      n_chk++;
      if (dc != 0) begin
         n_fail++;
         $display("FAIL mid_reset late_done: got %0d pulses expected 0", dc);
      end
      check_all_regs("mid_reset_after");
   endtask

   task automatic test_back_to_back();
      logic [15:0] ia;
      logic [15:0] ib;
      int acc [2];
      int n;
      load(3'd2, 16'h0102);
      load(3'd3, 16'h0304);
      load(3'd7, 16'h7777);
      ia = mk(5'b00100, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1);
      ib = mk(5'b00110, 3'd2, 3'd1, 3'd2, 1'b0, 1'b1);
      acc[0] = -1;
      acc[1] = -1;
      n = 0;
      @(negedge clk);
      instr = ia;
      instr_valid = 1'b1;
      for (int t = 0; t < 20 && n < 2; t++) begin
         if (t > 0) @(negedge clk);
         if (n == 1) begin
            instr = ib;
            ld_en = busy;
            ld_addr = 3'd7;
            ld_data = 16'hBEEF;
         end
         if (instr_ready === 1'b1) begin
            acc[n] = t;
            n++;
         end
      end
      @(negedge clk);
      instr_valid = 1'b0;
      ld_en = 1'b0;
      repeat (5) @(negedge clk);
      model_exec(ia);
      model_exec(ib);
      n_chk++;
      if (n != 2 || acc[1] - acc[0] != 4) begin
         n_fail++;
         $display("FAIL b2b spacing: got n=%0d gap=%0d expected 2/4",
                  n, acc[1] - acc[0]);
      end
      check_all_regs("b2b_regs");
      n_chk++;
      if (flags !== mflags) begin
         n_fail++;
         $display("FAIL b2b flags: got %h expected %h", flags, mflags);
      end
   endtask

   task automatic test_random();
      int da, dc, ec;
      logic ead, cs, r4;
      logic [15:0] ins;
      logic [4:0]  op;
      logic        ld;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            load(3'($urandom), 16'($urandom));
         end else begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
               op = 5'($urandom);
            end else begin
               do op = 5'($urandom); while (!is_legal(op));
            end
            ins[15:11] = op;
            ld = ($urandom_range(0, 2) == 0);
            run_instr(ins, ld, 3'($urandom), 16'($urandom),
                      da, dc, ec, ead, cs, r4);
            n_chk++;
            if (da != 3 || dc != 1 || r4 !== 1'b1) begin
               n_fail++;
               $display("FAIL rand timing op=%b: got at=%0d cnt=%0d rdy=%b expected 3/1/1",
                        op, da, dc, r4);
            end
            n_chk++;
            if (ec != (is_legal(op) ? 0 : 1)) begin
               n_fail++;
               $display("FAIL rand err op=%b: got %0d expected %0d",
                        op, ec, is_legal(op) ? 0 : 1);
            end
            n_chk++;
            if (flags !== mflags) begin
               n_fail++;
               $display("FAIL rand flags: got %h expected %h", flags, mflags);
            end
         end
         check_all_regs("rand_regs");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr = 16'd0;
      ld_en = 1'b0;
      ld_addr = 3'd0;
      ld_data = 16'd0;
      rd_addr = 3'd0;
      model_reset();
      test_reset();
      test_add();
      test_inc_carry();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous active-low reset, with clk and rst_n named as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 instr_valid  input  1  an instruction is offered.
REQ-005 instr_ready  output  1  the block can accept an instruction.
REQ-006 instr  input  16  instruction word: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [1] use_carry, [0] flag_we.
REQ-007 ld_en / ld_addr / ld_data  input  1/3/16  register-file load port.
REQ-008 rd_addr  input  3  and rd_data  output  16  provide an asynchronous register-file read for observation.
REQ-009 alu_a / alu_b  output  16 each  and alu_f  output  5  and alu_cin  output  1  drive the ALU operand, opcode and carry ports.
REQ-010 alu_result  input  16  and alu_status  input  6  are the combinational ALU outputs, with status bits {carry[5], zero[4], neg[3], ovf[2], parity[1], aux[0]}.
REQ-011 flags  output  6  is the architectural flag register, using the same bit layout as alu_status.
REQ-012 busy / done / err  output  1 each  signal in-flight, one-cycle completion, and illegal-opcode conditions.

Function
REQ-013 The register file SHALL be 8 x 16 bits; r0 is an ordinary writable register.
REQ-014 The FSM SHALL have exactly four states, IDLE, DECODE, EXEC and WB, visited in that order.
REQ-015 instr_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of instr_ready.
REQ-016 An accept occurs when instr_valid=1 and instr_ready=1 in IDLE; at that edge instr is latched and the FSM moves to DECODE.
REQ-017 DECODE SHALL register alu_a=reg[rs1], alu_b=reg[rs2], alu_f=opcode, and alu_cin = use_carry ? flags[5] : 0, then move to EXEC.
REQ-018 alu_a, alu_b, alu_f and alu_cin SHALL hold their values from DECODE through WB.
REQ-019 EXEC SHALL capture alu_result and alu_status into internal registers, then move to WB.
REQ-020 WB SHALL write the captured result to reg[rd], write the captured status to flags only if flag_we=1, assert done for exactly that cycle, and return to IDLE.
REQ-021 The latency SHALL be fixed: accept at edge N, done high during cycle N+3, instr_ready high again at cycle N+4.
REQ-022 Legal opcodes SHALL be 00001, 00011, 00100-00111, 01000-01011 and 10000-10111.
REQ-023 Any other opcode SHALL still traverse DECODE/EXEC/WB, assert err together with done in WB, and perform no register or flag write.
REQ-024 err and done SHALL be 0 in every other cycle.
REQ-025 ld_en SHALL be honored only in IDLE and ignored otherwise, with no queuing.
REQ-026 When ld_en and an instruction accept occur in the same IDLE cycle, the load SHALL complete first, so DECODE reads the loaded value.
REQ-027 When rd equals rs1 or rs2, the operands SHALL be the pre-write values, because the write occurs in WB after DECODE.
REQ-028 rd_data SHALL reflect a WB or load write from the cycle after that write's edge.

Reset
REQ-029 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, and all registers, flags, alu_a, alu_b, alu_f, alu_cin, done and err SHALL go to 0.
REQ-030 instr_ready SHALL be 1 after the reset edge.
REQ-031 Reset asserted in any state, including mid-operation, SHALL abort the instruction with no writeback and no done pulse.
REQ-032 Reset SHALL have priority over ld_en and over an instruction accept in the same cycle.

Verification
REQ-033 The bench SHALL load r1=0x0003 and r2=0x0004, then issue ADD (00100) rd=3 rs1=1 rs2=2 flag_we=1 -> done at accept+3, r3=0x0007, flags=6'b000000.
REQ-034 The bench SHALL load r1=0xFFFF with r0=0, then issue INC (00001) rd=4 rs1=1 rs2=0 flag_we=1 -> r4=0x0000, flags=6'h32 (carry, zero, parity).
REQ-035 Following REQ-034, the bench SHALL issue ADD_CARRY (00101) rd=5 rs1=0 rs2=0 use_carry=1 flag_we=0 -> alu_cin=1, r5=0x0001, flags still 6'h32.
REQ-036 The bench SHALL issue opcode 00010 rd=6 -> err=1 and done=1 in the same single cycle, r6 unchanged, flags unchanged.
REQ-037 The bench SHALL apply rst_n=0 for one edge while in EXEC of an ADD -> next cycle state IDLE, instr_ready=1, done=0, all registers and flags 0.
REQ-038 The bench SHALL hold instr_valid=1 continuously with two back-to-back instructions -> the second is accepted exactly 4 cycles after the first, and ld_en pulses during busy are ignored.
